// File: rtl/os_systolic_engine.sv
// os_systolic_engine
//   Output-stationary systolic matrix engine: Y = X * W over a runtime
//   reduction depth n_len. Each accepted beat carries one X column-vector
//   (M elements) and one W row-vector (K elements). The beat advances the
//   whole M x K PE grid by one step. After the last beat the grid is
//   flushed with zeros for M+K-1 cycles. Results then drain one row per
//   valid/ready handshake.
//
//   Ports
//     clk, rst_n      clock, synchronous active-low reset
//     start, n_len    job request (sampled in IDLE) and reduction depth
//     x_valid, X, W   operand beat; accepted when x_valid & in_ready
//     in_ready        high in FEED
//     y_valid, y_ready, y_row, y_idx   result row stream (row y_idx)
//     busy            high outside IDLE
//     done            one-cycle pulse on the final row handshake
//
//   Requires M >= 2 and K >= 2. ACC_WIDTH must be >= 2*DATA_WIDTH.

module os_systolic_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_w,
    output logic [ACC_WIDTH-1:0]  o_acc
);
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic        [ACC_WIDTH-1:0]    w_prod_ext;
    logic        [ACC_WIDTH-1:0]    r_acc;

    assign w_prod     = $signed(i_x) * $signed(i_w);
    // Size cast of a signed value sign-extends; the sum wraps naturally.
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_acc <= '0;
        else if (i_en)       r_acc <= r_acc + w_prod_ext;
    end

    assign o_acc = r_acc;
endmodule

module os_systolic_engine #(
    parameter  int M          = 4,
    parameter  int K          = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int ACC_WIDTH  = 40,
    parameter  int NMAX       = 256,
    localparam int N_W        = $clog2(NMAX + 1),
    localparam int IDX_W      = (M > 1) ? $clog2(M) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_W-1:0]          n_len,
    input  logic                    x_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH*M-1:0] X,
    input  logic [DATA_WIDTH*K-1:0] W,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [ACC_WIDTH*K-1:0]  y_row,
    output logic [IDX_W-1:0]        y_idx,
    output logic                    busy,
    output logic                    done
);
    localparam int FL_W = $clog2(M + K);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [N_W-1:0]  r_n_len, r_beat_cnt;
    logic [FL_W-1:0] r_flush_cnt;
    logic [IDX_W-1:0] r_y_idx;

    logic w_beat, w_adv, w_clr, w_last_beat, w_flush_end, w_y_hs, w_last_row;

    // Datapath nets
    logic [M-1:0][DATA_WIDTH-1:0]        w_xin, w_xs;   // skew-line inputs/outputs
    logic [K-1:0][DATA_WIDTH-1:0]        w_win, w_ws;
    logic [M-1:0][K-1:0][DATA_WIDTH-1:0] w_xg, w_wg;    // operands entering each PE
    logic [M-1:0][K-2:0][DATA_WIDTH-1:0] r_xp;          // x passed rightwards
    logic [M-2:0][K-1:0][DATA_WIDTH-1:0] r_wp;          // w passed downwards
    logic [M-1:0][K-1:0][ACC_WIDTH-1:0]  w_acc;

    // ---------------- control ----------------
    assign w_beat      = (r_state == S_FEED) && x_valid;
    // One global enable: a stalled FEED cycle freezes every register.
    assign w_adv       = w_beat || (r_state == S_FLUSH);
    assign w_clr       = (r_state == S_IDLE) && start;
    assign w_last_beat = (r_beat_cnt + N_W'(1)) == r_n_len;
    assign w_flush_end = r_flush_cnt == FL_W'(M + K - 2);
    assign w_y_hs      = (r_state == S_DRAIN) && y_ready;
    assign w_last_row  = r_y_idx == IDX_W'(M - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        y_valid     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = (n_len == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                if (w_beat && w_last_beat) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_flush_end) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                y_valid = 1'b1;
                if (w_y_hs && w_last_row) begin
                    w_state_nxt = S_IDLE;
                    // A reset in this cycle discards the job, so no done.
                    done        = rst_n;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_y_idx     <= '0;
        end else if (w_clr) begin
            r_n_len     <= n_len;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_y_idx     <= '0;
        end else begin
            if (w_beat)                r_beat_cnt  <= r_beat_cnt + N_W'(1);
            if (r_state == S_FLUSH)    r_flush_cnt <= r_flush_cnt + FL_W'(1);
            if (w_y_hs)                r_y_idx     <= w_last_row ? '0 : r_y_idx + IDX_W'(1);
        end
    end

    // ---------------- skew lines ----------------
    // Zeros are injected outside FEED so the flush adds nothing.
    assign w_xin = (r_state == S_FEED) ? X : '0;
    assign w_win = (r_state == S_FEED) ? W : '0;
    assign w_xs[0] = w_xin[0];
    assign w_ws[0] = w_win[0];

    for (genvar m = 1; m < M; m++) begin : g_xsk
        logic [m-1:0][DATA_WIDTH-1:0] r_sh;
        always_ff @(posedge clk) begin
            if (!rst_n || w_clr) r_sh <= '0;
            else if (w_adv) begin
                r_sh[0] <= w_xin[m];
                for (int i = 1; i < m; i++) r_sh[i] <= r_sh[i-1];
            end
        end
        assign w_xs[m] = r_sh[m-1];
    end

    for (genvar k = 1; k < K; k++) begin : g_wsk
        logic [k-1:0][DATA_WIDTH-1:0] r_sh;
        always_ff @(posedge clk) begin
            if (!rst_n || w_clr) r_sh <= '0;
            else if (w_adv) begin
                r_sh[0] <= w_win[k];
                for (int i = 1; i < k; i++) r_sh[i] <= r_sh[i-1];
            end
        end
        assign w_ws[k] = r_sh[k-1];
    end

    // ---------------- PE grid ----------------
    // Operand pair t meets at PE(m,k) on step t+m+k.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clr) begin
            r_xp <= '0;
            r_wp <= '0;
        end else if (w_adv) begin
            for (int m = 0; m < M; m++)
                for (int k = 0; k < K - 1; k++) r_xp[m][k] <= w_xg[m][k];
            for (int m = 0; m < M - 1; m++)
                for (int k = 0; k < K; k++) r_wp[m][k] <= w_wg[m][k];
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_row
        for (genvar k = 0; k < K; k++) begin : g_col
            if (k == 0) begin : g_xl
                assign w_xg[m][k] = w_xs[m];
            end else begin : g_xn
                assign w_xg[m][k] = r_xp[m][k-1];
            end
            if (m == 0) begin : g_wt
                assign w_wg[m][k] = w_ws[k];
            end else begin : g_wn
                assign w_wg[m][k] = r_wp[m-1][k];
            end

            os_systolic_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst_n(rst_n),
                .i_clr(w_clr),
                .i_en (w_adv),
                .i_x  (w_xg[m][k]),
                .i_w  (w_wg[m][k]),
                .o_acc(w_acc[m][k])
            );
        end
    end

    // ---------------- result stream ----------------
    always_comb begin
        y_row = '0;
        if (r_state == S_DRAIN) y_row = w_acc[r_y_idx];
    end
    assign y_idx = r_y_idx;
endmodule

// File: tb/tb_os_systolic_engine.sv
module tb_os_systolic_engine;
    localparam int M = 4, K = 4, DW = 16, AW = 40, NMAX = 256;
    localparam int N_W = $clog2(NMAX + 1);

    logic              clk = 1'b0;
    logic              rst_n, start, x_valid, y_ready;
    logic [N_W-1:0]    n_len;
    logic [DW*M-1:0]   X;
    logic [DW*K-1:0]   W;
    logic              in_ready, y_valid, busy, done;
    logic [AW*K-1:0]   y_row;
    logic [1:0]        y_idx;

    int nvec = 0, nerr = 0, cyc = 0, t_start = 0, t_done = 0;
    logic signed [63:0] exp_tab [M][K];

    os_systolic_engine #(.M(M), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .NMAX(NMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_len(n_len),
        .x_valid(x_valid), .in_ready(in_ready), .X(X), .W(W),
        .y_valid(y_valid), .y_ready(y_ready), .y_row(y_row), .y_idx(y_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] splat(input int v);
        logic [15:0] e;
        e = v[15:0];
        return {4{e}};
    endfunction

    task automatic set_exp(input int v);
        for (int m = 0; m < M; m++)
            for (int k = 0; k < K; k++) exp_tab[m][k] = v;
    endtask

    task automatic start_job(input logic [63:0] xv, input logic [63:0] wv, input int n);
        X = xv; W = wv; n_len = N_W'(n); start = 1'b1;
        t_start = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic beat(input logic [63:0] xv, input logic [63:0] wv);
        X = xv; W = wv; x_valid = 1'b1;
        chk("in_ready_beat", in_ready, 1);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic bubble();
        x_valid = 1'b0;
        X = splat(99); W = splat(99);   // garbage that must not be absorbed
        chk("in_ready_bubble", in_ready, 1);
        tick();
    endtask

    task automatic chk_row(input int r);
        logic signed [63:0] e;
        chk("y_valid", y_valid, 1);
        chk("y_idx", y_idx, r);
        for (int k = 0; k < K; k++) begin
            e = $signed(y_row[k*AW +: AW]);
            chk($sformatf("y[%0d][%0d]", r, k), e, exp_tab[r][k]);
        end
    endtask

    task automatic drain(input int stall_row, input int stall_n);
        for (int i = 0; i < 64 && !y_valid; i++) tick();
        chk("y_valid_wait", y_valid, 1);
        for (int r = 0; r < M; r++) begin
            if (r == stall_row) begin
                y_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk_row(r);
                    chk("done_stall", done, 0);
                    tick();
                end
                y_ready = 1'b1;
            end
            chk_row(r);
            chk("done_row", done, (r == M - 1) ? 1 : 0);
            if (r == M - 1) t_done = cyc;
            tick();
        end
        chk("busy_after_done", busy, 0);
        chk("done_after", done, 0);
        chk("y_valid_after", y_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
        n_len = '0; X = '0; W = '0;
        tick(); tick();

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_row", (y_row == '0) ? 1 : 0, 1);
        chk("rst_y_idx", y_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // 1: all ones, n=8 -> 8, latency 20 cycles inclusive
        start_job(splat(1), splat(1), 8);
        for (int i = 0; i < 8; i++) beat(splat(1), splat(1));
        chk("in_ready_flush", in_ready, 0);
        chk("busy_flush", busy, 1);
        set_exp(8);
        drain(-1, 0);
        chk("latency", t_done - t_start + 1, 20);

        // 2: back-to-back start, -3*5*3 = -45
        start_job(splat(-3), splat(5), 3);
        for (int i = 0; i < 3; i++) beat(splat(-3), splat(5));
        set_exp(-45);
        drain(-1, 0);

        // 3: bubbles between beats do not change the result
        start_job(splat(1), splat(1), 8);
        for (int i = 0; i < 8; i++) begin
            beat(splat(1), splat(1));
            if (i < 7) bubble();
        end
        set_exp(8);
        drain(-1, 0);

        // 4: 7 * -2 * 5 = -70, row 1 back-pressured for 5 cycles
        start_job(splat(7), splat(-2), 5);
        for (int i = 0; i < 5; i++) beat(splat(7), splat(-2));
        set_exp(-70);
        drain(1, 5);

        // 5: distinct elements over two beats (checks skew alignment)
        start_job('0, '0, 2);
        beat({16'sd4, 16'sd3, 16'sd2, 16'sd1}, {-16'sd3, 16'sd2, -16'sd1, 16'sd1});
        beat({16'sd2, -16'sd1, 16'sd0, 16'sd5}, {16'sd1, 16'sd0, 16'sd3, 16'sd2});
        exp_tab[0] = '{11, 14, 2, 2};
        exp_tab[1] = '{2, -2, 4, -6};
        exp_tab[2] = '{1, -6, 6, -10};
        exp_tab[3] = '{8, 2, 8, -10};
        drain(-1, 0);

        // 6: n_len = 0 goes straight to DRAIN with zero rows
        start_job(splat(5), splat(5), 0);
        chk("n0_in_ready", in_ready, 0);
        chk("n0_y_valid", y_valid, 1);
        set_exp(0);
        drain(-1, 0);

        // 7: reset mid-FEED discards the job; new job with ignored start
        start_job(splat(9), splat(9), 6);
        for (int i = 0; i < 3; i++) beat(splat(9), splat(9));
        rst_n = 1'b0;
        chk("rst_mid_done", done, 0);
        tick();
        rst_n = 1'b1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_y_valid", y_valid, 0);
        chk("rst_mid_done2", done, 0);
        start_job(splat(2), splat(3), 4);
        beat(splat(2), splat(3));
        start = 1'b1; n_len = N_W'(1);   // must be ignored while busy
        beat(splat(2), splat(3));
        start = 1'b0;
        beat(splat(2), splat(3));
        beat(splat(2), splat(3));
        set_exp(24);
        drain(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
